// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the program counter, fetches one word at a time over a req/ack
// handshake and hands it to the decoder on valid/ready, applying redirect/halt at accept.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_REQ   | imem_req high at pc, waiting for imem_ack
// S_ISSUE | ir holds a fetched word, waiting for ir_ready
// S_HALTED| decoder reported halt; fetch stopped until reset
module instruction_fetch_unit #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 20,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt_in,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  ir_pc_nxt;
    logic [INSTR_W-1:0] ir_nxt;
    logic [CNT_W-1:0]   retired_nxt;

    assign imem_req  = (state == S_REQ);
    assign ir_valid  = (state == S_ISSUE);
    assign halted    = (state == S_HALTED);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            pc      <= '0;
            ir      <= '0;
            ir_pc   <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            ir_pc   <= ir_pc_nxt;
            retired <= retired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        ir_pc_nxt   = ir_pc;
        retired_nxt = retired;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    ir_nxt    = imem_data;
                    ir_pc_nxt = pc;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ir_ready) begin
                    retired_nxt = retired + CNT_W'(1);
                    // halt wins over redirect; pc keeps the sequential value
                    if (halt_in) begin
                        state_nxt = S_HALTED;
                    end else if (redirect_en) begin
                        pc_nxt    = redirect_addr;
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction decoder. Holds the 10-bit program counter and requests 20-bit instruction words from instruction memory over a req/ack handshake. It presents each fetched word to the decoder/execute side on a valid/ready handshake, then applies jump/branch redirects and halt reported back for the issued word.

Parameters:
ADDR_W, 10, program counter / instruction memory address width
INSTR_W, 20, instruction word width
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction memory request, high only in state REQ
imem_addr  output  ADDR_W  fetch address, equals pc
imem_ack  input  1  memory returns imem_data this cycle; sampled only while imem_req=1
imem_data  input  INSTR_W  instruction word from memory
ir  output  INSTR_W  instruction register, feeds decoder instruction input
ir_pc  output  ADDR_W  address the current ir was fetched from
ir_valid  output  1  ir holds an unconsumed instruction
ir_ready  input  1  downstream accepts ir this cycle
redirect_en  input  1  taken jump/branch for the word being accepted
redirect_addr  input  ADDR_W  target address for redirect
halt_in  input  1  accepted word is a halt (decoder halt)
pc  output  ADDR_W  current program counter
halted  output  1  fetch permanently stopped until reset
retired  output  CNT_W  count of accepted instructions, wraps

Behaviour:
- Reset (synchronous, active-high): state=REQ, pc=0, ir=0, ir_pc=0, retired=0, halted=0. ir_valid=0; imem_req=1 in the first cycle after reset is released.
- Reset has priority over all other inputs at any cycle. Reset mid-wait abandons the outstanding request; memory must tolerate a dropped request.
- States: REQ, ISSUE, HALTED. Moore outputs: imem_req=(state==REQ), ir_valid=(state==ISSUE), halted=(state==HALTED). imem_addr=pc combinationally.
- REQ: imem_req=1, imem_addr stable until ack.
  - imem_ack=1 at an edge: ir<=imem_data, ir_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (0x3FF→0x000), state<=ISSUE.
  - imem_ack=0: remain in REQ, no state change.
- ISSUE: ir and ir_pc held stable while ir_ready=0; no memory request.
  - Handshake (ir_valid & ir_ready) at an edge: retired<=retired+1 (wraps).
  - If halt_in=1: state<=HALTED. Halt has priority over redirect_en; pc is unchanged.
  - Else if redirect_en=1: pc<=redirect_addr, state<=REQ.
  - Else: state<=REQ with the already-incremented pc.
- redirect_en and halt_in are ignored in any cycle without a handshake.
- HALTED: imem_req=0, ir_valid=0; imem_ack, ir_ready, redirect_en and halt_in are ignored. Exit only via reset.
- imem_ack while imem_req=0 is ignored (no capture, no pc change).
- Throughput: with zero-wait memory (ack in the request cycle) and ir_ready=1, one instruction every 2 cycles. Each memory wait state or ready stall adds exactly 1 cycle.
- No speculative fetch: at most one instruction in flight. The redirect therefore never needs a flush.

Test Plan:
1. Reset, then memory acks in the same cycle; words 0x0000B@0, 0x00015@1, 0x00000@2; ir_ready=1 → imem_addr 0,1,2 on cycles 1,3,5. ir_valid high on cycles 2,4,6 with ir=0x0000B,0x00015,0x00000 and ir_pc=0,1,2. Assert halt_in with the third word → halted=1, retired=3.
2. Wait states: ack delayed 3 cycles at addr 0x004 → imem_req=1 and imem_addr=0x004 stable for 4 cycles, ir_valid=0, pc=0x004 throughout; after ack, ir=data and pc=0x005.
3. Backpressure: ir_valid=1, ir_ready=0 for 4 cycles → ir, ir_pc and pc stable, imem_req=0, retired unchanged; ir_ready=1 → retired+1 and imem_req=1 on the next cycle.
4. Redirect: word at 0x010 accepted with redirect_en=1, redirect_addr=0x155 → next imem_addr=0x155, ir_pc of the next word=0x155. Asserting redirect_en while ir_ready=0 has no effect.
5. Halt priority: handshake with halt_in=1 and redirect_en=1 (addr 0x200) → halted=1, pc unchanged; imem_req stays 0 for 20 cycles despite toggled imem_ack/ir_ready; reset → pc=0, imem_req=1.
6. Wrap and reset mid-operation: fetch at 0x3FF → pc=0x000 after ack. Reset asserted while waiting for ack at 0x123, then ack arriving one cycle later → pc=0, ir=0, ack ignored, and the fetch restarts at address 0.
